n101_reset_sequencer: RTL and testbench

- Generates the per-domain reset vector that drives the async-reset register vectors in the peripheral subsystem.
- Assertion is asynchronous: all domains reset immediately on `reset`.
- Deassertion is synchronized to `clock`, held for a minimum time, then released one domain at a time in a staggered order.
- Also accepts a synchronous software reset request that re-runs the sequence without a chip-level reset.

---
 rtl/n101_rstseq_pkg.sv | 22 ++
 rtl/n101_reset_sync.sv | 22 ++
 rtl/n101_reset_sequencer.sv | 134 +++++++++++++
 tb/tb_n101_reset_sequencer.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/n101_rstseq_pkg.sv
// Shared types and helpers for the n101 reset sequencer.
// The optional reset-cause output is enabled with N101_RSTSEQ_CAUSE_EN.
package n101_rstseq_pkg;

  typedef enum logic [1:0] {
    StSync    = 2'd0,
    StHold    = 2'd1,
    StRelease = 2'd2,
    StRun     = 2'd3
  } rstseq_state_e;

  localparam logic [1:0] CauseReset = 2'b01;
  localparam logic [1:0] CauseSw    = 2'b10;

  // Width that holds every value 0..max(hold, stagger).
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned stagger);
    int unsigned m;
    m = (hold > stagger) ? hold : stagger;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/n101_reset_sync.sv
// Reset synchronizer: asynchronous assert, release shifted through STAGES flops.
module n101_reset_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  output logic sync_rst
);

  logic [STAGES-1:0] chain_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      chain_q <= '1;
    end else begin
      chain_q <= chain_q << 1;
    end
  end

  assign sync_rst = chain_q[STAGES-1];

endmodule

// File: rtl/n101_reset_sequencer.sv
// Staggered per-domain reset sequencer with software re-sequence request.
// Optional io_cause output when N101_RSTSEQ_CAUSE_EN is defined.
module n101_reset_sequencer
  import n101_rstseq_pkg::*;
#(
  parameter int unsigned NUM_DOMAINS = 5,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned STAGGER     = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   io_sw_rst,
  output logic [NUM_DOMAINS-1:0] io_rst_out,
  output logic                   io_done,
  output logic                   io_busy
`ifdef N101_RSTSEQ_CAUSE_EN
  ,
  output logic [1:0]             io_cause
`endif
);

  localparam int unsigned CntW = cnt_width(HOLD_CYCLES, STAGGER);
  localparam int unsigned IdxW = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CntW-1:0] HoldLast = CntW'(HOLD_CYCLES - 1);
  localparam logic [CntW-1:0] StagLast = CntW'(STAGGER - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(NUM_DOMAINS - 1);

  rstseq_state_e          state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [IdxW-1:0]        idx_q, idx_d;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   done_q, done_d;
  logic                   busy_q;
  logic                   sync_rst;
  logic                   sw_accept;

  // The state register acts as the last synchronizer flop, so SYNC ends
  // on edge SYNC_STAGES after release.
  n101_reset_sync #(
    .STAGES(SYNC_STAGES - 1)
  ) u_sync (
    .clock   (clock),
    .reset   (reset),
    .sync_rst(sync_rst)
  );

  assign sw_accept = io_sw_rst && (state_q != StSync);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_d   = rst_q;
    unique case (state_q)
      StSync: begin
        if (!sync_rst) begin
          state_d = StHold;
          cnt_d   = '0;
        end
      end
      StHold: begin
        if (sw_accept) begin
          cnt_d = '0;
        end else if (cnt_q == HoldLast) begin
          state_d = StRelease;
          cnt_d   = '0;
          idx_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StRelease, StRun: begin
        if (sw_accept) begin
          state_d = StHold;
          cnt_d   = '0;
          rst_d   = '1;
        end else if (state_q == StRelease) begin
          if (cnt_q == '0) begin
            rst_d[idx_q] = 1'b0;
            cnt_d        = StagLast;
            if (idx_q == IdxLast) begin
              state_d = StRun;
            end else begin
              idx_d = idx_q + IdxW'(1);
            end
          end else begin
            cnt_d = cnt_q - CntW'(1);
          end
        end
      end
    endcase
  end

  // Done/busy are registered one edge behind the RUN transition.
  assign done_d = (state_q == StRun) && !io_sw_rst;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= StSync;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      busy_q  <= !done_d;
    end
  end

  assign io_rst_out = rst_q;
  assign io_done    = done_q;
  assign io_busy    = busy_q;

`ifdef N101_RSTSEQ_CAUSE_EN
  logic [1:0] cause_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cause_q <= CauseReset;
    end else if (sw_accept) begin
      cause_q <= CauseSw;
    end
  end

  assign io_cause = cause_q;
`endif

endmodule

// File: tb/tb_n101_reset_sequencer.sv
// Bench for n101_reset_sequencer: default instance plus a minimal-parameter instance,
// checked against an edge-arithmetic model. Honors N101_RSTSEQ_CAUSE_EN.
module tb_n101_reset_sequencer;

  localparam int NA = 5, SA = 2, HA = 16, GA = 4;
  localparam int NB = 1, SB = 3, HB = 1,  GB = 1;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_sw_rst;
  logic [4:0] rst_a;
  logic       done_a, busy_a;
  logic [0:0] rst_b;
  logic       done_b, busy_b;
`ifdef N101_RSTSEQ_CAUSE_EN
  logic [1:0] cause_a, cause_b;
`endif

  always #5 clock = ~clock;

  n101_reset_sequencer dut_a (
    .clock     (clock),
    .reset     (reset),
    .io_sw_rst (io_sw_rst),
    .io_rst_out(rst_a),
    .io_done   (done_a),
    .io_busy   (busy_a)
`ifdef N101_RSTSEQ_CAUSE_EN
    ,
    .io_cause  (cause_a)
`endif
  );

  n101_reset_sequencer #(
    .NUM_DOMAINS(NB),
    .SYNC_STAGES(SB),
    .HOLD_CYCLES(HB),
    .STAGGER    (GB)
  ) dut_b (
    .clock     (clock),
    .reset     (reset),
    .io_sw_rst (io_sw_rst),
    .io_rst_out(rst_b),
    .io_done   (done_b),
    .io_busy   (busy_b)
`ifdef N101_RSTSEQ_CAUSE_EN
    ,
    .io_cause  (cause_b)
`endif
  );

  int errors = 0;
  int checks = 0;
  // Model: edges since release, edge at which the hold count last restarted, cause.
  int k = 0;
  int anc_a = SA;
  int anc_b = SB;
  logic [1:0] cause_ma = 2'b01;
  logic [1:0] cause_mb = 2'b01;

  typedef struct {
    int   edge_n;
    logic sw;
    logic [4:0] rst;
    logic done;
    logic busy;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s edge=%0d got=%0h want=%0h", name, k, act, exp);
    end
  endtask

  function automatic logic [4:0] exp_rst(int n, int h, int s, int anc, int kk);
    logic [4:0] r;
    r = '0;
    for (int i = 0; i < n; i++) r[i] = (kk < anc + h + 1 + s * i);
    return r;
  endfunction

  function automatic logic exp_done(int n, int h, int s, int anc, int kk);
    return kk >= anc + h + 1 + s * (n - 1) + 1;
  endfunction

  task automatic compare_all();
    logic [4:0] ea, eb;
    logic da, db;
    if (reset) begin
      ea = 5'h1f; eb = 5'h01; da = 1'b0; db = 1'b0;
    end else begin
      ea = exp_rst(NA, HA, GA, anc_a, k);
      eb = exp_rst(NB, HB, GB, anc_b, k);
      da = exp_done(NA, HA, GA, anc_a, k);
      db = exp_done(NB, HB, GB, anc_b, k);
    end
    check("model_rst_a", rst_a, ea);
    check("model_done_a", done_a, da);
    check("model_busy_a", busy_a, !da);
    check("model_rst_b", rst_b, eb[0]);
    check("model_done_b", done_b, db);
    check("model_busy_b", busy_b, !db);
`ifdef N101_RSTSEQ_CAUSE_EN
    check("model_cause_a", cause_a, cause_ma);
    check("model_cause_b", cause_b, cause_mb);
`endif
  endtask

  // One clock edge: update the model from inputs sampled at the edge, then compare.
  task automatic step();
    @(posedge clock);
    if (reset) begin
      k = 0; anc_a = SA; anc_b = SB; cause_ma = 2'b01; cause_mb = 2'b01;
    end else begin
      k++;
      if (io_sw_rst && k > SA) begin anc_a = k; cause_ma = 2'b10; end
      if (io_sw_rst && k > SB) begin anc_b = k; cause_mb = 2'b10; end
    end
    #1;
    compare_all();
  endtask

  task automatic step_to(input int target);
    while (k < target) step();
  endtask

  task automatic run_table();
    foreach (tbl[j]) begin
      while (k < tbl[j].edge_n) begin
        io_sw_rst = tbl[j].sw;
        step();
      end
      io_sw_rst = 1'b0;
      check("tbl_rst", rst_a, tbl[j].rst);
      check("tbl_done", done_a, tbl[j].done);
      check("tbl_busy", busy_a, tbl[j].busy);
    end
  endtask

  initial begin
    // Power-on timeline; sw requests during SYNC (edges 1..2) must be ignored.
    tbl.push_back('{1,  1'b1, 5'h1f, 1'b0, 1'b1});
    tbl.push_back('{2,  1'b1, 5'h1f, 1'b0, 1'b1});
    tbl.push_back('{18, 1'b0, 5'h1f, 1'b0, 1'b1});
    tbl.push_back('{19, 1'b0, 5'h1e, 1'b0, 1'b1});
    tbl.push_back('{22, 1'b0, 5'h1e, 1'b0, 1'b1});
    tbl.push_back('{23, 1'b0, 5'h1c, 1'b0, 1'b1});
    tbl.push_back('{27, 1'b0, 5'h18, 1'b0, 1'b1});
    tbl.push_back('{31, 1'b0, 5'h10, 1'b0, 1'b1});
    tbl.push_back('{35, 1'b0, 5'h00, 1'b0, 1'b1});
    tbl.push_back('{36, 1'b0, 5'h00, 1'b1, 1'b0});
    tbl.push_back('{40, 1'b0, 5'h00, 1'b1, 1'b0});

    reset = 1'b1;
    io_sw_rst = 1'b0;
    #1;
    check("async_reset_rst", rst_a, 5'h1f);
    check("async_reset_busy", busy_a, 1'b1);
    repeat (3) step();
    reset = 1'b0;
    run_table();

    // Async assert mid-release, then the full timeline again.
    reset = 1'b1;
    io_sw_rst = 1'b0;
    step();
    reset = 1'b0;
    step_to(24);
    #3;
    reset = 1'b1;
    #1;
    check("midrel_rst", rst_a, 5'h1f);
    check("midrel_done", done_a, 1'b0);
    check("midrel_busy", busy_a, 1'b1);
    repeat (2) step();
    reset = 1'b0;
    run_table();

    // Software reset pulse in RUN at edge 50.
    step_to(49);
    io_sw_rst = 1'b1;
    step();
    io_sw_rst = 1'b0;
    check("sw_run_rst", rst_a, 5'h1f);
    check("sw_run_done", done_a, 1'b0);
`ifdef N101_RSTSEQ_CAUSE_EN
    check("sw_run_cause", cause_a, 2'b10);
`endif
    step_to(66);
    check("sw_run_e66", rst_a, 5'h1f);
    step();
    check("sw_run_e67", rst_a, 5'h1e);
    step_to(83);
    check("sw_run_e83", rst_a, 5'h00);
    check("sw_run_e83_done", done_a, 1'b0);
    step();
    check("sw_run_e84_done", done_a, 1'b1);

    // Software reset held through HOLD: last sampled high at edge 14.
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    step_to(4);
    io_sw_rst = 1'b1;
    repeat (10) step();
    io_sw_rst = 1'b0;
    step_to(30);
    check("swhold_e30", rst_a, 5'h1f);
    step();
    check("swhold_e31", rst_a, 5'h1e);

    // Reset and sw together: reset wins.
    reset = 1'b1;
    io_sw_rst = 1'b1;
    step();
`ifdef N101_RSTSEQ_CAUSE_EN
    check("prio_cause", cause_a, 2'b01);
`endif
    check("prio_rst", rst_a, 5'h1f);
    io_sw_rst = 1'b0;
    reset = 1'b0;

    // Minimal-parameter instance timeline.
    step_to(4);
    check("param_e4_rst", rst_b, 1'b1);
    step();
    check("param_e5_rst", rst_b, 1'b0);
    check("param_e5_done", done_b, 1'b0);
    step();
    check("param_e6_done", done_b, 1'b1);

    // Randomized traffic against the model.
    for (int n = 0; n < 2000; n++) begin
      if (reset) begin
        if ($urandom_range(0, 2) == 0) reset = 1'b0;
      end else if ($urandom_range(0, 299) == 0) begin
        reset = 1'b1;
      end
      io_sw_rst = ($urandom_range(0, 39) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
